// File: rtl/fetch_pc_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Instruction-fetch stage at the front of the pipeline. It owns the PC and
// issues one instruction-memory request at a time. The returned word is held
// in a one-entry buffer until decode takes it. A taken branch/jump resolved in
// EX (ResolveValid & PCNextSrc) redirects fetch to BranchTarget. Any request
// or buffered instruction still in flight is discarded.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   PCNextSrc           branch_unit select, 1 = take BranchTarget
//   ResolveValid        qualifies PCNextSrc (EX holds a branch/jump)
//   BranchTarget        redirect address from EX
//   imem_req_valid/ready/addr   request channel to instruction memory
//   imem_resp_valid/data        response channel (one beat per request)
//   if_valid/ready      handshake to decode
//   if_instr, if_pc     buffered instruction and its PC
//   if_pc_plus4         if_pc + 4, modulo 2^XLEN
//   if_misalign, if_bad_addr    (FETCH_MISALIGN_TRAP_EN only) misaligned
//                               redirect report
//
// Build option FETCH_MISALIGN_TRAP_EN:
//   defined   - a redirect to a target that is not word-aligned does not
//               fetch. It presents a nop flagged if_misalign, then idles until
//               the next redirect.
//   undefined - the low two target bits are cleared on redirect.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_REQ  | request for PC driven, waiting for imem_req_ready
// S_WAIT | request accepted, waiting for the response beat
// S_HOLD | instruction (or misalign trap) presented to decode
// S_IDLE | trap taken by decode; no fetch until the next redirect
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCNextSrc,
    input  logic            ResolveValid,
    input  logic [XLEN-1:0] BranchTarget,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            if_misalign,
    output logic [XLEN-1:0] if_bad_addr
`endif
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_IDLE = 2'd3;

    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0] LOW_BITS  = XLEN'(3);

    logic [1:0]      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] if_pc_q;
    logic [31:0]     instr_q;
    logic            drop;      // the outstanding response belongs to a dead request
    logic            trap_q;    // the HOLD entry is a misalign trap, not a fetched word

    logic            redirect;
    logic            tgt_trap;
    logic [XLEN-1:0] tgt;

    assign redirect = ResolveValid & PCNextSrc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic [XLEN-1:0] bad_addr_q;

    assign tgt      = BranchTarget;
    assign tgt_trap = |(BranchTarget & LOW_BITS);
`else
    assign tgt      = BranchTarget & ~LOW_BITS;
    assign tgt_trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            drop    <= 1'b0;
            trap_q  <= 1'b0;
            instr_q <= NOP_INSTR;
            if_pc_q <= RESET_PC;
        end else if (redirect) begin
            // Redirect outranks every other event in every state.
            pc <= tgt;
            if (tgt_trap) begin
                state   <= S_HOLD;
                drop    <= 1'b0;
                trap_q  <= 1'b1;
                instr_q <= NOP_INSTR;
                if_pc_q <= tgt;
            end else begin
                trap_q <= 1'b0;
                case (state)
                    S_REQ: begin
                        // Old address accepted on this edge: its reply must be dropped.
                        if (imem_req_ready) begin
                            state <= S_WAIT;
                            drop  <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (imem_resp_valid) begin
                            state <= S_REQ;
                            drop  <= 1'b0;
                        end else begin
                            drop  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_REQ;
                        drop  <= 1'b0;
                    end
                endcase
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            instr_q <= imem_resp_data;
                            if_pc_q <= pc;
                            pc      <= pc + PC_STEP;
                            state   <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (if_ready) begin
                        state  <= trap_q ? S_IDLE : S_REQ;
                        trap_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bad_addr_q <= '0;
        end else if (redirect && tgt_trap) begin
            bad_addr_q <= BranchTarget;
        end
    end

    assign if_misalign = trap_q;
    assign if_bad_addr = bad_addr_q;
`endif

    // Gate with rst so no request is visible while reset is held.
    assign imem_req_valid = (state == S_REQ) & ~rst;
    assign imem_req_addr  = pc;
    assign if_valid       = (state == S_HOLD);
    assign if_instr       = instr_q;
    assign if_pc          = if_pc_q;
    assign if_pc_plus4    = if_pc_q + PC_STEP;

endmodule

// File: tb/tb_fetch_pc_unit.sv
`timescale 1ns/1ps
module tb_fetch_pc_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, PCNextSrc, ResolveValid, imem_req_ready, imem_resp_valid, if_ready;
    logic [31:0] BranchTarget, imem_resp_data;

    logic        imem_req_valid, if_valid;
    logic [31:0] imem_req_addr, if_instr, if_pc, if_pc_plus4;
    logic        w_req_valid, w_if_valid;
    logic [31:0] w_req_addr, w_if_instr, w_if_pc, w_if_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        if_misalign, w_if_misalign;
    logic [31:0] if_bad_addr, w_if_bad_addr;
`endif

    fetch_pc_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .PCNextSrc(PCNextSrc), .ResolveValid(ResolveValid),
        .BranchTarget(BranchTarget), .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .if_pc_plus4(if_pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .if_misalign(if_misalign), .if_bad_addr(if_bad_addr)
`endif
    );

    // Second instance exercises PC wrap from the top of the address space.
    // It shares all inputs and runs in lockstep timing with dut.
    fetch_pc_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .PCNextSrc(PCNextSrc), .ResolveValid(ResolveValid),
        .BranchTarget(BranchTarget), .imem_req_valid(w_req_valid),
        .imem_req_ready(imem_req_ready), .imem_req_addr(w_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .if_valid(w_if_valid), .if_ready(if_ready), .if_instr(w_if_instr), .if_pc(w_if_pc),
        .if_pc_plus4(w_if_pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .if_misalign(w_if_misalign), .if_bad_addr(w_if_bad_addr)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    // instruction memory model: one outstanding request, configurable latency
    bit          mem_pending = 1'b0;
    int          mem_cnt     = 0;
    logic [31:0] mem_paddr   = '0;
    int          mem_lat     = 1;
    bit          rand_lat    = 1'b0;
    bit          ovr_en      = 1'b0;
    logic [31:0] ovr_data    = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    // Called #1+ after a clock edge; advances one cycle and updates the memory.
    task automatic tick();
        logic        acc, rs, rf;
        logic [31:0] a;
        acc = imem_req_valid & imem_req_ready;
        a   = imem_req_addr;
        rs  = rst;
        rf  = imem_resp_valid;
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        if (rs) begin
            mem_pending = 1'b0;
        end else begin
            if (rf) mem_pending = 1'b0;
            if (acc) begin
                mem_pending = 1'b1;
                mem_paddr   = a;
                mem_cnt     = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
            end
            if (mem_pending) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = ovr_en ? ovr_data : memf(mem_paddr);
                    ovr_en          = 1'b0;
                end
            end
        end
        cycle++;
    endtask

    task automatic do_reset();
        rst = 1'b1; if_ready = 1'b1; imem_req_ready = 1'b1;
        mem_lat = 1; rand_lat = 1'b0; ovr_en = 1'b0;
        ResolveValid = 1'b0; PCNextSrc = 1'b0; BranchTarget = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic redirect_pulse(input logic [31:0] t);
        ResolveValid = 1'b1; PCNextSrc = 1'b1; BranchTarget = t;
        tick();
        ResolveValid = 1'b0; PCNextSrc = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_ready = 1'b1; imem_req_ready = 1'b1;
        ResolveValid = 1'b0; PCNextSrc = 1'b0; BranchTarget = '0;
        repeat (2) tick();
        n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); else n_pass++;
        n_checks++; if (if_valid !== 1'b0) $display("FAIL reset_if_valid: got %b want 0", if_valid); else n_pass++;
        n_checks++; if (if_instr !== NOP) $display("FAIL reset_if_instr: got %h want %h", if_instr, NOP); else n_pass++;
        n_checks++; if (if_pc !== 32'h0) $display("FAIL reset_if_pc: got %h want 0", if_pc); else n_pass++;
        n_checks++; if (if_pc_plus4 !== 32'h4) $display("FAIL reset_pc_plus4: got %h want 4", if_pc_plus4); else n_pass++;
        n_checks++; if (w_if_pc !== 32'hFFFF_FFFC) $display("FAIL reset_wrap_if_pc: got %h want fffffffc", w_if_pc); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (imem_req_valid !== 1'b1) $display("FAIL first_req_valid: got %b want 1", imem_req_valid); else n_pass++;
        n_checks++; if (imem_req_addr !== 32'h0) $display("FAIL first_req_addr: got %h want 0", imem_req_addr); else n_pass++;
    endtask

    task automatic test_sequential();
        logic [31:0] ra [3];
        logic [31:0] pa [3];
        logic [31:0] ia [3];
        int          hc [3];
        int          nr, nh, c0;
        logic [31:0] e;
        for (int i = 0; i < 3; i++) begin ra[i] = 'x; pa[i] = 'x; ia[i] = 'x; hc[i] = -1; end
        nr = 0; nh = 0; c0 = cycle;
        for (int k = 0; k < 40 && nh < 3; k++) begin
            if (imem_req_valid && imem_req_ready && nr < 3) begin ra[nr] = imem_req_addr; nr++; end
            if (if_valid && if_ready) begin pa[nh] = if_pc; ia[nh] = if_instr; hc[nh] = cycle - c0; nh++; end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            e = 32'(4 * i);
            n_checks++; if (ra[i] !== e) $display("FAIL seq_req_addr[%0d]: got %h want %h", i, ra[i], e); else n_pass++;
            n_checks++; if (pa[i] !== e) $display("FAIL seq_if_pc[%0d]: got %h want %h", i, pa[i], e); else n_pass++;
            n_checks++; if (ia[i] !== memf(e)) $display("FAIL seq_if_instr[%0d]: got %h want %h", i, ia[i], memf(e)); else n_pass++;
            n_checks++; if (hc[i] != 2 + 3 * i) $display("FAIL seq_timing[%0d]: got cycle %0d want %0d", i, hc[i], 2 + 3 * i); else n_pass++;
        end
    endtask

    task automatic test_stall();
        if_ready = 1'b0;
        for (int k = 0; k < 20 && !if_valid; k++) tick();
        n_checks++; if (if_valid !== 1'b1) $display("FAIL stall_reach_hold: got if_valid %b want 1", if_valid); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (if_valid !== 1'b1) $display("FAIL stall_if_valid[%0d]: got %b want 1", k, if_valid); else n_pass++;
            n_checks++; if (if_pc !== 32'hC) $display("FAIL stall_if_pc[%0d]: got %h want c", k, if_pc); else n_pass++;
            n_checks++; if (if_instr !== memf(32'hC)) $display("FAIL stall_if_instr[%0d]: got %h want %h", k, if_instr, memf(32'hC)); else n_pass++;
            n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL stall_no_req[%0d]: got %b want 0", k, imem_req_valid); else n_pass++;
            tick();
        end
        if_ready = 1'b1;
        tick();
        n_checks++; if (imem_req_valid !== 1'b1) $display("FAIL stall_next_req_valid: got %b want 1", imem_req_valid); else n_pass++;
        n_checks++; if (imem_req_addr !== 32'h10) $display("FAIL stall_next_req_addr: got %h want 10", imem_req_addr); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        bit          found, seen_valid, got_req;
        logic [31:0] first_addr;
        do_reset();
        mem_lat = 3;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (imem_req_valid && imem_req_ready && imem_req_addr == 32'h8) found = 1'b1;
            tick();
        end
        n_checks++; if (found !== 1'b1) $display("FAIL rw_req8_seen: got %b want 1", found); else n_pass++;
        ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
        redirect_pulse(32'h100);
        seen_valid = 1'b0; got_req = 1'b0; first_addr = 'x;
        for (int k = 0; k < 20 && !got_req; k++) begin
            if (if_valid) seen_valid = 1'b1;
            if (imem_req_valid) begin got_req = 1'b1; first_addr = imem_req_addr; end
            else tick();
        end
        n_checks++; if (seen_valid !== 1'b0) $display("FAIL rw_stale_presented: got %b want 0", seen_valid); else n_pass++;
        n_checks++; if (first_addr !== 32'h100) $display("FAIL rw_next_req_addr: got %h want 100", first_addr); else n_pass++;
        for (int k = 0; k < 20 && !if_valid; k++) tick();
        n_checks++; if (if_pc !== 32'h100) $display("FAIL rw_if_pc: got %h want 100", if_pc); else n_pass++;
        n_checks++; if (if_instr !== memf(32'h100)) $display("FAIL rw_if_instr: got %h want %h", if_instr, memf(32'h100)); else n_pass++;
    endtask

    task automatic test_redirect_hold();
        if_ready = 1'b0;
        for (int k = 0; k < 30 && !if_valid; k++) tick();
        n_checks++; if (if_valid !== 1'b1) $display("FAIL rh_reach_hold: got %b want 1", if_valid); else n_pass++;
        tick();
        if_ready = 1'b1;
        redirect_pulse(32'h200);
        n_checks++; if (if_valid !== 1'b0) $display("FAIL rh_killed: got if_valid %b want 0", if_valid); else n_pass++;
        n_checks++; if (imem_req_valid !== 1'b1) $display("FAIL rh_req_valid: got %b want 1", imem_req_valid); else n_pass++;
        n_checks++; if (imem_req_addr !== 32'h200) $display("FAIL rh_req_addr: got %h want 200", imem_req_addr); else n_pass++;
        for (int k = 0; k < 30 && !if_valid; k++) tick();
        n_checks++; if (if_pc !== 32'h200) $display("FAIL rh_if_pc: got %h want 200", if_pc); else n_pass++;
        n_checks++; if (if_instr !== memf(32'h200)) $display("FAIL rh_if_instr: got %h want %h", if_instr, memf(32'h200)); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        n_checks++; if (w_req_valid !== 1'b1) $display("FAIL wrap_req_valid: got %b want 1", w_req_valid); else n_pass++;
        n_checks++; if (w_req_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_req_addr: got %h want fffffffc", w_req_addr); else n_pass++;
        tick();
        tick();
        n_checks++; if (w_if_valid !== 1'b1) $display("FAIL wrap_if_valid: got %b want 1", w_if_valid); else n_pass++;
        n_checks++; if (w_if_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_if_pc: got %h want fffffffc", w_if_pc); else n_pass++;
        n_checks++; if (w_if_pc_plus4 !== 32'h0) $display("FAIL wrap_pc_plus4: got %h want 0", w_if_pc_plus4); else n_pass++;
        n_checks++; if (w_if_instr !== memf(32'h0)) $display("FAIL wrap_if_instr: got %h want %h", w_if_instr, memf(32'h0)); else n_pass++;
`ifdef FETCH_MISALIGN_TRAP_EN
        n_checks++; if (w_if_misalign !== 1'b0) $display("FAIL wrap_misalign: got %b want 0", w_if_misalign); else n_pass++;
`endif
        tick();
        n_checks++; if (w_req_valid !== 1'b1) $display("FAIL wrap_next_req_valid: got %b want 1", w_req_valid); else n_pass++;
        n_checks++; if (w_req_addr !== 32'h0) $display("FAIL wrap_next_req_addr: got %h want 0", w_req_addr); else n_pass++;
    endtask

    task automatic test_misalign();
        do_reset();
        imem_req_ready = 1'b0;
        redirect_pulse(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
        n_checks++; if (if_valid !== 1'b1) $display("FAIL mis_if_valid: got %b want 1", if_valid); else n_pass++;
        n_checks++; if (if_misalign !== 1'b1) $display("FAIL mis_flag: got %b want 1", if_misalign); else n_pass++;
        n_checks++; if (if_bad_addr !== 32'h102) $display("FAIL mis_bad_addr: got %h want 102", if_bad_addr); else n_pass++;
        n_checks++; if (if_pc !== 32'h102) $display("FAIL mis_if_pc: got %h want 102", if_pc); else n_pass++;
        n_checks++; if (if_instr !== NOP) $display("FAIL mis_if_instr: got %h want %h", if_instr, NOP); else n_pass++;
        n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL mis_no_req: got %b want 0", imem_req_valid); else n_pass++;
        imem_req_ready = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL mis_idle_req[%0d]: got %b want 0", k, imem_req_valid); else n_pass++;
            n_checks++; if (if_valid !== 1'b0) $display("FAIL mis_idle_valid[%0d]: got %b want 0", k, if_valid); else n_pass++;
            tick();
        end
        redirect_pulse(32'h300);
        n_checks++; if (imem_req_valid !== 1'b1) $display("FAIL mis_resume_valid: got %b want 1", imem_req_valid); else n_pass++;
        n_checks++; if (imem_req_addr !== 32'h300) $display("FAIL mis_resume_addr: got %h want 300", imem_req_addr); else n_pass++;
`else
        n_checks++; if (imem_req_valid !== 1'b1) $display("FAIL align_req_valid: got %b want 1", imem_req_valid); else n_pass++;
        n_checks++; if (imem_req_addr !== 32'h100) $display("FAIL align_req_addr: got %h want 100", imem_req_addr); else n_pass++;
        imem_req_ready = 1'b1;
        for (int k = 0; k < 20 && !if_valid; k++) tick();
        n_checks++; if (if_pc !== 32'h100) $display("FAIL align_if_pc: got %h want 100", if_pc); else n_pass++;
        n_checks++; if (if_instr !== memf(32'h100)) $display("FAIL align_if_instr: got %h want %h", if_instr, memf(32'h100)); else n_pass++;
`endif
        imem_req_ready = 1'b1;
    endtask

    // Reference model: the delivered stream is sequential (+4) from the last
    // redirect target or reset PC; an instruction shown during a redirect
    // cycle is killed; every request asks for the next PC decode should see.
    task automatic test_random();
        logic [31:0] exp_pc, prev_addr, t;
        bit          prev_stall, red;
        int          hs;
        do_reset();
        rand_lat = 1'b1;
        exp_pc = 32'h0; prev_stall = 1'b0; prev_addr = '0; hs = 0;
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 499) == 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            if_ready       = ($urandom_range(0, 9) < 7);
            ResolveValid   = ($urandom_range(0, 9) == 0);
            PCNextSrc      = ($urandom_range(0, 2) != 0);
            t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_0FFF);
`ifdef FETCH_MISALIGN_TRAP_EN
            t = t & ~32'h3;
`endif
            BranchTarget = t;
            #1;
            if (rst) begin
                exp_pc = 32'h0;
                prev_stall = 1'b0;
            end else begin
                red = ResolveValid & PCNextSrc;
                if (if_valid) begin
                    n_checks++; if (if_pc !== exp_pc) $display("FAIL rnd_if_pc@%0d: got %h want %h", cycle, if_pc, exp_pc); else n_pass++;
                    n_checks++; if (if_instr !== memf(exp_pc)) $display("FAIL rnd_if_instr@%0d: got %h want %h", cycle, if_instr, memf(exp_pc)); else n_pass++;
                    n_checks++; if (if_pc_plus4 !== exp_pc + 32'h4) $display("FAIL rnd_pc_plus4@%0d: got %h want %h", cycle, if_pc_plus4, exp_pc + 32'h4); else n_pass++;
                end
                if (imem_req_valid) begin
                    n_checks++; if (imem_req_addr !== exp_pc) $display("FAIL rnd_req_addr@%0d: got %h want %h", cycle, imem_req_addr, exp_pc); else n_pass++;
                    n_checks++; if (mem_pending !== 1'b0) $display("FAIL rnd_one_outstanding@%0d: got pending %b want 0", cycle, mem_pending); else n_pass++;
                end
                if (prev_stall) begin
                    n_checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, prev_addr})
                        $display("FAIL rnd_req_stable@%0d: got %b/%h want 1/%h", cycle, imem_req_valid, imem_req_addr, prev_addr); else n_pass++;
                end
                prev_stall = imem_req_valid & ~imem_req_ready & ~red;
                prev_addr  = imem_req_addr;
                if (red) exp_pc = t & ~32'h3;
                else if (if_valid && if_ready) begin exp_pc = exp_pc + 32'h4; hs++; end
            end
            tick();
        end
        rst = 1'b0; ResolveValid = 1'b0; PCNextSrc = 1'b0;
        n_checks++; if (hs <= 100) $display("FAIL rnd_progress: got %0d handshakes want >100", hs); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; PCNextSrc = 1'b0; ResolveValid = 1'b0; BranchTarget = '0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0; if_ready = 1'b1;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_misalign();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
